// File: rtl/dmem_sram_responder.sv
// Single-port 64-bit data-memory responder: req/gnt handshake, optional wait states, byte strobes.
// Define DMEM_SRAM_RESPONDER_RANGE_CHECK_EN to return bus errors for addresses outside the array.
module dmem_sram_responder #(
    parameter logic [63:0] MEM_BASE    = 64'h0000_0000_0001_0000,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        dmem_req,
    input  logic [63:0] dmem_addr,
    input  logic        dmem_wen,
    input  logic [7:0]  dmem_strb,
    input  logic [63:0] dmem_wdata,
    output logic        dmem_gnt,
    output logic        dmem_err,
    output logic [63:0] dmem_rdata
);

    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic        wen_q, wen_d;
    logic [7:0]  strb_q, strb_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [63:0] mem_q [MEM_DEPTH];

    logic              enter_resp;
    logic [63:0]       acc_addr;
    logic              acc_wen;
    logic [7:0]        acc_strb;
    logic [63:0]       acc_wdata;
    logic [60:0]       word_off;
    logic [IDX_W-1:0]  acc_idx;
    logic              in_range;
    logic              mem_we;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            strb_q  <= strb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal gets a default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (dmem_req) begin
                    cnt_d = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem_gnt   = (state_q == ST_RESP);
        dmem_rdata = rdata_q;
        dmem_err   = err_q;
    end

    always_comb begin
        addr_d  = addr_q;
        wen_d   = wen_q;
        strb_d  = strb_q;
        wdata_d = wdata_q;
        if (state_q == ST_IDLE && dmem_req) begin
            addr_d  = dmem_addr;
            wen_d   = dmem_wen;
            strb_d  = dmem_strb;
            wdata_d = dmem_wdata;
        end
    end

    // With zero wait states the array is accessed on the accepting edge, straight from the inputs.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr  = dmem_addr;
            acc_wen   = dmem_wen;
            acc_strb  = dmem_strb;
            acc_wdata = dmem_wdata;
        end else begin
            acc_addr  = addr_q;
            acc_wen   = wen_q;
            acc_strb  = strb_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        word_off = acc_addr[63:3] - MEM_BASE[63:3];
        acc_idx  = word_off[IDX_W-1:0];
`ifdef DMEM_SRAM_RESPONDER_RANGE_CHECK_EN
        // Lower-bound compare first, so a wrapped subtraction can never look in range.
        in_range = (acc_addr[63:3] >= MEM_BASE[63:3]) && (word_off[60:IDX_W] == '0);
`else
        in_range = 1'b1;
`endif
        mem_we  = enter_resp && acc_wen && in_range;
        rdata_d = (enter_resp && in_range) ? mem_q[acc_idx] : '0;
`ifdef DMEM_SRAM_RESPONDER_RANGE_CHECK_EN
        err_d   = enter_resp && !in_range;
`else
        err_d   = 1'b0;
`endif
    end

    // NOTE: the array has no reset; contents must survive g_resetn and a reset would block RAM mapping.
    always_ff @(posedge g_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (acc_strb[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{acc_addr[2:0], word_off};

endmodule

// File: tb/tb_dmem_sram_responder.sv
// Bench for dmem_sram_responder: three instances (0, 3 and 5 wait states) against a word-array model.
module tb_dmem_sram_responder;

    localparam logic [63:0] BASE  = 64'h0000_0000_0001_0000;
    localparam int          DEPTH = 1024;
    localparam logic [63:0] TOP   = BASE + 64'(8 * DEPTH);

    int waits [3] = '{0, 3, 5};

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, wen;
    logic [2:0][63:0] addr, wdata;
    logic [2:0][7:0]  strb;
    logic        gnt0, gnt1, gnt2, err0, err1, err2;
    logic [63:0] rdata0, rdata1, rdata2;

    logic [63:0] mdl   [3][DEPTH];
    bit          known [3][DEPTH];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [63:0] obs_rd;

    always #5 clk = ~clk;

    dmem_sram_responder #(.MEM_BASE(BASE), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .g_clk(clk), .g_resetn(rst_n), .dmem_req(req[0]), .dmem_addr(addr[0]), .dmem_wen(wen[0]),
        .dmem_strb(strb[0]), .dmem_wdata(wdata[0]), .dmem_gnt(gnt0), .dmem_err(err0), .dmem_rdata(rdata0));
    dmem_sram_responder #(.MEM_BASE(BASE), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (
        .g_clk(clk), .g_resetn(rst_n), .dmem_req(req[1]), .dmem_addr(addr[1]), .dmem_wen(wen[1]),
        .dmem_strb(strb[1]), .dmem_wdata(wdata[1]), .dmem_gnt(gnt1), .dmem_err(err1), .dmem_rdata(rdata1));
    dmem_sram_responder #(.MEM_BASE(BASE), .MEM_DEPTH(DEPTH), .WAIT_CYCLES(5)) u_dut2 (
        .g_clk(clk), .g_resetn(rst_n), .dmem_req(req[2]), .dmem_addr(addr[2]), .dmem_wen(wen[2]),
        .dmem_strb(strb[2]), .dmem_wdata(wdata[2]), .dmem_gnt(gnt2), .dmem_err(err2), .dmem_rdata(rdata2));

    function automatic logic get_gnt(input int u);
        return (u == 0) ? gnt0 : (u == 1) ? gnt1 : gnt2;
    endfunction

    function automatic logic get_err(input int u);
        return (u == 0) ? err0 : (u == 1) ? err1 : err2;
    endfunction

    function automatic logic [63:0] get_rdata(input int u);
        return (u == 0) ? rdata0 : (u == 1) ? rdata1 : rdata2;
    endfunction

    function automatic bit addr_in_range(input logic [63:0] a);
        logic [63:0] aa;
        aa = {a[63:3], 3'b000};
        return (aa >= BASE) && (aa < TOP);
    endfunction

    function automatic int word_of(input logic [63:0] a);
        logic [63:0] off;
        off = ({a[63:3], 3'b000} - BASE) >> 3;
        return int'(off % 64'(DEPTH));
    endfunction

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One complete handshake; expectations come from the word array before it is updated.
    task automatic txn(input int u, input logic [63:0] a, input logic w, input logic [7:0] s,
                       input logic [63:0] d, input bit drop, input string tag, output logic [63:0] rd);
        int          ix;
        bit          hit;
        bit          exp_known;
        logic        exp_err;
        logic [63:0] exp_rd;
        ix  = word_of(a);
        hit = addr_in_range(a);
`ifdef DMEM_SRAM_RESPONDER_RANGE_CHECK_EN
        exp_err = !hit;
`else
        exp_err = 1'b0;
        hit     = 1'b1;
`endif
        exp_rd    = hit ? mdl[u][ix] : 64'd0;
        exp_known = !hit || known[u][ix];
        if (hit && w) begin
            for (int i = 0; i < 8; i++) begin
                if (s[i]) begin
                    mdl[u][ix][8*i +: 8] = d[8*i +: 8];
                end
            end
            if (s == 8'hFF) known[u][ix] = 1'b1;
        end

        @(negedge clk);
        req[u] = 1'b1; addr[u] = a; wen[u] = w; strb[u] = s; wdata[u] = d;
        for (int k = 1; k <= waits[u] + 1; k++) begin
            @(negedge clk);
            if (k <= waits[u]) check({tag, "_gnt_early"}, 64'(get_gnt(u)), 64'd0);
            if (drop && k == 1 && waits[u] > 0) begin
                req[u]   = 1'b0;
                addr[u]  = {$urandom, $urandom};
                wdata[u] = {$urandom, $urandom};
                wen[u]   = ~w;
                strb[u]  = ~s;
            end
        end
        rd = get_rdata(u);
        check({tag, "_gnt"}, 64'(get_gnt(u)), 64'd1);
        check({tag, "_err"}, 64'(get_err(u)), 64'(exp_err));
        if (exp_known) check({tag, "_rdata"}, rd, exp_rd);
        req[u] = 1'b0;
        @(negedge clk);
        check({tag, "_gnt_pulse"}, 64'(get_gnt(u)), 64'd0);
        check({tag, "_err_idle"}, 64'(get_err(u)), 64'd0);
        check({tag, "_rdata_idle"}, get_rdata(u), 64'd0);
    endtask

    initial begin
        logic [63:0] a, d, old3;
        int          sel;
        rst_n = 1'b0;
        req = '0; wen = '0; addr = '0; wdata = '0; strb = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check("rst_gnt", 64'(get_gnt(u)), 64'd0);
            check("rst_err", 64'(get_err(u)), 64'd0);
            check("rst_rdata", get_rdata(u), 64'd0);
        end
        rst_n = 1'b1;

        for (int u = 0; u < 3; u++) begin
            for (int wd = 0; wd < 17; wd++) begin
                a = (wd == 16) ? BASE + 64'(8 * (DEPTH - 1)) : BASE + 64'(8 * wd);
                txn(u, a, 1'b1, 8'hFF, {$urandom, $urandom}, 1'b0, "init", obs_rd);
            end
        end

        txn(0, 64'h10008, 1'b1, 8'hFF, 64'h1122334455667788, 1'b0, "w_full", obs_rd);
        txn(0, 64'h10008, 1'b0, 8'h00, 64'h0, 1'b0, "r_full", obs_rd);
        check("r_full_const", obs_rd, 64'h1122334455667788);
        txn(0, 64'h10010, 1'b1, 8'hFF, 64'hAAAAAAAAAAAAAAAA, 1'b0, "w_aaaa", obs_rd);
        txn(0, 64'h10010, 1'b1, 8'h0F, 64'h0000000012345678, 1'b0, "w_part", obs_rd);
        check("w_part_old", obs_rd, 64'hAAAAAAAAAAAAAAAA);
        txn(0, 64'h10010, 1'b0, 8'h00, 64'h0, 1'b0, "r_part", obs_rd);
        check("r_part_const", obs_rd, 64'hAAAAAAAA12345678);
        txn(0, 64'h10018, 1'b1, 8'h00, 64'hDEADBEEFDEADBEEF, 1'b0, "w_nostrb", obs_rd);
        txn(0, 64'h10018, 1'b0, 8'hFF, 64'h0, 1'b0, "r_nostrb", obs_rd);

        txn(1, BASE + 64'd40, 1'b0, 8'h00, 64'h0, 1'b0, "w3_held", obs_rd);
        txn(1, BASE + 64'd48, 1'b1, 8'hF0, 64'h0123456789ABCDEF, 1'b1, "w3_drop", obs_rd);
        txn(1, BASE + 64'd48, 1'b0, 8'h00, 64'h0, 1'b1, "r3_drop", obs_rd);

        for (int u = 0; u < 3; u++) begin
            txn(u, 64'h0FFF8, 1'b1, 8'hFF, {$urandom, $urandom}, 1'b0, "w_below", obs_rd);
            txn(u, TOP, 1'b1, 8'hFF, {$urandom, $urandom}, 1'b0, "w_top", obs_rd);
            txn(u, BASE, 1'b0, 8'h00, 64'h0, 1'b0, "r_word0", obs_rd);
            txn(u, TOP - 64'd8, 1'b0, 8'h00, 64'h0, 1'b0, "r_wordlast", obs_rd);
        end

        for (int u = 0; u < 3; u++) begin
            for (int n = 0; n < 25; n++) begin
                sel = int'($urandom_range(0, 9));
                if (sel < 8)       a = BASE + 64'(8 * $urandom_range(0, 15));
                else if (sel == 8) a = BASE - 64'd8;
                else               a = TOP + 64'(8 * $urandom_range(0, 15));
                a[2:0] = 3'($urandom);
                txn(u, a, 1'($urandom), 8'($urandom), {$urandom, $urandom}, 1'($urandom), "rand", obs_rd);
            end
        end

        old3 = mdl[2][3];
        d    = ~old3;
        @(negedge clk);
        req[2] = 1'b1; addr[2] = BASE + 64'd24; wen[2] = 1'b1; strb[2] = 8'hFF; wdata[2] = d;
        @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rst_wait_gnt", 64'(gnt2), 64'd0);
        end
        check("rst_wait_rdata", rdata2, 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("post_rst_gnt", 64'(gnt2), 64'd0);
        end
        txn(2, BASE + 64'd24, 1'b0, 8'h00, 64'h0, 1'b0, "r_after_rst", obs_rd);
        check("r_after_rst_old", obs_rd, old3);
        txn(0, 64'h10008, 1'b0, 8'h00, 64'h0, 1'b0, "r_keep", obs_rd);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_sram_responder.md
DMEM_SRAM_RESPONDER -- requirements
Module: dmem_sram_responder

Interface
REQ-001 Parameter MEM_BASE, default 64'h0000_0000_0001_0000: byte address of word 0; SHALL be 8-byte aligned.
REQ-002 Parameter MEM_DEPTH, default 1024: number of 64-bit words; SHALL be a power of two, 2..65536.
REQ-003 Parameter WAIT_CYCLES, default 0: wait states inserted before grant; range 0..15.
REQ-004 Clocking: one clock, g_clk; reset g_resetn is asynchronous, active-low.
REQ-005 g_clk  input  1  global clock.
REQ-006 g_resetn  input  1  asynchronous active-low reset.
REQ-007 dmem_req  input  1  request, held by initiator until granted.
REQ-008 dmem_addr  input  64  doubleword-aligned request address; bits [2:0] ignored.
REQ-009 dmem_wen  input  1  1 = write, 0 = read.
REQ-010 dmem_strb  input  8  byte write strobes; bit i enables byte lane i, data bits [8i+7:8i].
REQ-011 dmem_wdata  input  64  write data, pre-positioned on byte lanes.
REQ-012 dmem_gnt  output  1  response valid; transaction complete.
REQ-013 dmem_err  output  1  bus error; valid only while dmem_gnt=1.
REQ-014 dmem_rdata  output  64  read data; valid only while dmem_gnt=1.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 IDLE with dmem_req=1: capture addr, wen, strb, wdata; load wait counter with WAIT_CYCLES; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-017 IDLE with dmem_req=0: stay in IDLE; no array access.
REQ-018 WAIT: decrement counter each cycle; on the edge where counter goes 1->0, enter RESP.
REQ-019 Latency: request first seen in IDLE at cycle N; dmem_gnt=1 in cycle N+1+WAIT_CYCLES, for exactly one cycle.
REQ-020 RESP: dmem_gnt=1; next state IDLE unconditionally, so back-to-back requests are granted at most every 2+WAIT_CYCLES cycles.
REQ-021 Inputs are sampled only in IDLE; input changes during WAIT/RESP are ignored.
REQ-022 A captured transaction always completes, even if dmem_req drops before grant; dmem_gnt is still asserted.
REQ-023 Word index = (addr - MEM_BASE) >> 3, truncated to log2(MEM_DEPTH) bits.
REQ-024 Array read and write both occur on the clock edge entering RESP; dmem_rdata is registered and holds pre-write contents (read-before-write).
REQ-025 Write: update only byte lanes with dmem_strb[i]=1; dmem_strb=0 writes nothing; reads ignore dmem_strb.
REQ-026 dmem_rdata is returned for writes as well as reads.
REQ-027 Outside RESP: dmem_gnt=0, dmem_err=0, dmem_rdata=0.
REQ-028 In range: MEM_BASE <= addr < MEM_BASE + 8*MEM_DEPTH, computed without 64-bit overflow wrap.
REQ-029 Out-of-range, with range checking compiled in: no array write; in RESP, dmem_err=1 and dmem_rdata=0; latency unchanged.

Reset
REQ-030 Asynchronous assertion forces: state IDLE, counter 0, dmem_gnt=0, dmem_err=0, dmem_rdata=0, captured registers 0.
REQ-031 Reset in WAIT aborts the transaction; no array write and no grant.
REQ-032 Array contents are not reset and are preserved across reset.
REQ-033 First sample of dmem_req is on the first rising edge after deassertion.

Configuration
REQ-034 Macro DMEM_SRAM_RESPONDER_RANGE_CHECK_EN defined: range check and error response per REQ-028/029.
REQ-035 Macro undefined: no range comparator; every address maps by REQ-023 (aliasing modulo MEM_DEPTH); dmem_err is tied 0.

Verification
REQ-036 WAIT_CYCLES=0; write addr 0x10008, strb 0xFF, wdata 0x1122334455667788; then read 0x10008 -> first gnt in cycle N+1; read returns 0x1122334455667788, err=0.
REQ-037 Word at 0x10010 = 0xAAAAAAAAAAAAAAAA; write strb 0x0F, wdata 0x0000000012345678; then read -> 0xAAAAAAAA12345678; the write's own gnt returns 0xAAAAAAAAAAAAAAAA.
REQ-038 WAIT_CYCLES=3; read request held in cycle N -> gnt only in cycle N+4; req dropped in cycle N+1 -> gnt still in N+4.
REQ-039 Range check on; write to 0x0FFF8, then to MEM_BASE+8*MEM_DEPTH -> gnt with err=1, rdata=0; array unchanged. Range check off: second address aliases to word 0.
REQ-040 WAIT_CYCLES=5; assert g_resetn=0 two cycles after accepting a write -> no gnt; target word keeps its old value; next request after reset completes normally.
